// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and common types for the framebuffer source.
package vga_pkg;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned FB_DEPTH = 19200;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned CRD_W    = 10;

    typedef logic [8:0] rgb9_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/vga_fb_source_if.sv
// Processor-side write and fill-control bus of the framebuffer source.
interface vga_fb_source_if;
    import vga_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    rgb9_t             wr_data;
    logic              clr_start;
    rgb9_t             clr_color;
    logic              clr_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_start, clr_color,
        input  wr_ready, clr_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_start, clr_color,
        output wr_ready, clr_busy
    );
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port (1-cycle latency).
module fb_ram
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH,
    parameter int unsigned AW    = ADDR_W
) (
    input  logic          clk25,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rgb9_t         wdata,
    input  logic [AW-1:0] raddr,
    output rgb9_t         rdata
);
    rgb9_t mem [DEPTH];
    rgb9_t rdata_q;

    // Read-before-write: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk25) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/vga_fb_source.sv
// Scaled framebuffer pixel source for a 640x480 VGA controller, with processor writes and a full-buffer fill engine.
module vga_fb_source
    import vga_pkg::*;
#(
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned FB_W       = 160,
    parameter int unsigned FB_H       = 120
) (
    input  logic             clk25,
    input  logic             rst,
    vga_fb_source_if.slave   bus,
    output rgb9_t            rgb,
    output logic [CRD_W-1:0] px_x,
    output logic [CRD_W-1:0] px_y,
    output logic             px_active,
    output logic             frame_start
);
    localparam int unsigned DEPTH = FB_W * FB_H;
    localparam int unsigned AW    = ADDR_W;

    state_e          state_q, state_d;
    logic [AW-1:0]   fill_q, fill_d;
    rgb9_t           color_q, color_d;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    rgb9_t           ram_wdata;

    logic [CRD_W-1:0] lx_q, lx_d, ly_q, ly_d;
    logic [CRD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic             s1_vld_q, s1_vld_d;
    logic [CRD_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
    logic             px_active_q, px_active_d;
    logic             frame_start_q, frame_start_d;
    rgb9_t            rgb_q, rgb_d;
    logic [CRD_W-1:0] fx, fy;
    logic             la_active;
    logic [AW-1:0]    rd_addr;
    rgb9_t            rd_data;

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            color_q <= color_d;
        end
    end

    // Fill engine and processor write arbitration; a fill request beats a concurrent write.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        color_d   = color_q;
        ram_we    = 1'b0;
        ram_waddr = bus.wr_addr;
        ram_wdata = bus.wr_data;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    fill_d  = '0;
                    color_d = bus.clr_color;
                    state_d = ST_CLEAR;
                end else if (bus.wr_valid && (bus.wr_addr < AW'(DEPTH))) begin
                    ram_we = 1'b1;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = fill_q;
                ram_wdata = color_q;
                fill_d    = fill_q + AW'(1);
                if (fill_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.wr_ready = !rst || ((state_q == ST_IDLE) && !bus.clr_start);
    assign bus.clr_busy = (state_q == ST_CLEAR);

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            lx_q          <= '0;
            ly_q          <= '0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            s1_vld_q      <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            px_active_q   <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            lx_q          <= lx_d;
            ly_q          <= ly_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            s1_vld_q      <= s1_vld_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            px_active_q   <= px_active_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    // Lookahead position runs two cycles ahead of px_x/px_y: RAM read stage, then output stage.
    always_comb begin
        lx_d = lx_q + CRD_W'(1);
        ly_d = ly_q;
        if (lx_q == CRD_W'(H_TOTAL - 1)) begin
            lx_d = '0;
            ly_d = (ly_q == CRD_W'(V_TOTAL - 1)) ? '0 : ly_q + CRD_W'(1);
        end

        la_active = (lx_q < CRD_W'(H_ACTIVE)) && (ly_q < CRD_W'(V_ACTIVE));
        fx        = lx_q >> SCALE_LOG2;
        fy        = ly_q >> SCALE_LOG2;
        if (!la_active) begin
            rd_addr = '0;
        end else if (FB_W == 160) begin
            rd_addr = (AW'(fy) << 7) + (AW'(fy) << 5) + AW'(fx);
        end else begin
            rd_addr = AW'(fy * FB_W) + AW'(fx);
        end

        s1_x_d        = lx_q;
        s1_y_d        = ly_q;
        s1_vld_d      = 1'b1;
        px_x_d        = s1_x_q;
        px_y_d        = s1_y_q;
        px_active_d   = s1_vld_q && (s1_x_q < CRD_W'(H_ACTIVE)) && (s1_y_q < CRD_W'(V_ACTIVE));
        frame_start_d = s1_vld_q && (s1_x_q == '0) && (s1_y_q == '0);
        rgb_d         = px_active_d ? rd_data : rgb9_t'(0);
    end

    fb_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fb_ram (
        .clk25 (clk25),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign rgb         = rgb_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign px_active   = px_active_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_fb_source.sv
// Randomized self-checking bench for vga_fb_source against a framebuffer-array reference model.
module tb_vga_fb_source;
    import vga_pkg::*;

    logic clk25 = 1'b0;
    logic rst   = 1'b0;
    always #20 clk25 = ~clk25;

    vga_fb_source_if bus ();

    rgb9_t       rgb;
    logic [9:0]  px_x, px_y;
    logic        px_active, frame_start;

    vga_fb_source #(
        .SCALE_LOG2 (2),
        .FB_W       (160),
        .FB_H       (120)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .bus         (bus),
        .rgb         (rgb),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_active   (px_active),
        .frame_start (frame_start)
    );

    rgb9_t fb_model [19200];
    int    tests = 0;
    int    fails = 0;

    task automatic do_write(input logic [14:0] a, input rgb9_t d, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        @(negedge clk25);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        while (!ok && n < 100) begin
            #1;
            if (bus.wr_ready === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk25);
                n++;
            end
        end
        @(posedge clk25);
        #1;
        bus.wr_valid = 1'b0;
        if (ok && a < 15'd19200) fb_model[a] = d;
    endtask

    // Resets the display, then walks the given number of lines comparing every cycle to the model.
    task automatic test_display(input int lines, input string tag);
        int    pos, x, y;
        bit    act;
        rgb9_t exp_rgb;
        @(negedge clk25);
        rst = 1'b0;
        repeat (2) @(negedge clk25);
        rst = 1'b1;
        @(negedge clk25);
        tests++;
        if (px_active !== 1'b0 || frame_start !== 1'b0 || px_x !== 10'd0 || px_y !== 10'd0) begin
            fails++;
            $display("FAIL %s_pipe_fill: px=(%0d,%0d) act=%b fs=%b, required px=(0,0) act=0 fs=0",
                     tag, px_x, px_y, px_active, frame_start);
        end
        for (int k = 2; k < lines * 800 + 2; k++) begin
            @(negedge clk25);
            pos = k - 2;
            x   = pos % 800;
            y   = pos / 800;
            act = (x < 640) && (y < 480);
            exp_rgb = act ? fb_model[(y / 4) * 160 + x / 4] : 9'h000;
            tests++;
            if (px_x !== 10'(x) || px_y !== 10'(y) || px_active !== act || frame_start !== (pos == 0)) begin
                fails++;
                $display("FAIL %s_coord: got px=(%0d,%0d) act=%b fs=%b, required px=(%0d,%0d) act=%b fs=%b",
                         tag, px_x, px_y, px_active, frame_start, x, y, act, (pos == 0));
            end
            tests++;
            if (rgb !== exp_rgb) begin
                fails++;
                $display("FAIL %s_rgb at (%0d,%0d): got %h, required %h", tag, x, y, rgb, exp_rgb);
            end
        end
    endtask

    task automatic test_reset;
        int n;
        bit seen;
        rst = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
        repeat (3) @(negedge clk25);
        tests++;
        if (rgb !== 9'h000 || px_x !== 10'd0 || px_y !== 10'd0 || px_active !== 1'b0 ||
            frame_start !== 1'b0 || bus.clr_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rgb=%h px=(%0d,%0d) act=%b fs=%b busy=%b, required all zero",
                     rgb, px_x, px_y, px_active, frame_start, bus.clr_busy);
        end
        tests++;
        if (bus.wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_wr_ready: got %b, required 1", bus.wr_ready);
        end
        rst  = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk25);
            n++;
            if (frame_start === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || n != 2) begin
            fails++;
            $display("FAIL first_frame_start: seen=%b after %0d cycles, required after 2 cycles", seen, n);
        end
    endtask

    task automatic test_clear;
        rgb9_t c;
        int    busy_n, ready_bad, n;
        c = 9'h038;
        busy_n = 0;
        ready_bad = 0;
        n = 0;
        @(negedge clk25);
        bus.clr_color = c;
        bus.clr_start = 1'b1;
        @(posedge clk25);
        #1;
        bus.clr_start = 1'b0;
        while (n < 20500) begin
            @(negedge clk25);
            n++;
            if (bus.clr_start === 1'b1) bus.clr_start = 1'b0;
            if (bus.clr_busy !== 1'b1) break;
            busy_n++;
            if (bus.wr_ready !== 1'b0) ready_bad++;
            // A second request mid-fill must neither restart nor recolour the fill.
            if (busy_n == 5000) begin
                bus.clr_color = 9'h1C0;
                bus.clr_start = 1'b1;
            end
        end
        tests++;
        if (busy_n != 19200) begin
            fails++;
            $display("FAIL clear_busy_len: got %0d cycles, required 19200", busy_n);
        end
        tests++;
        if (ready_bad != 0) begin
            fails++;
            $display("FAIL clear_wr_ready: high on %0d busy cycles, required 0", ready_bad);
        end
        for (int i = 0; i < 19200; i++) fb_model[i] = c;
    endtask

    task automatic test_pixel_writes;
        bit ok;
        int bad;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            do_write(15'($urandom_range(0, 319)), 9'($urandom), ok);
            if (!ok) bad++;
        end
        do_write(15'd0, 9'h1FF, ok);
        if (!ok) bad++;
        do_write(15'd161, 9'h007, ok);
        if (!ok) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL write_handshake: %0d writes not accepted, required 0", bad);
        end
        test_display(8, "pix");
    endtask

    task automatic test_out_of_range;
        bit ok;
        do_write(15'd19200, 9'($urandom), ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL oob_19200_handshake: accepted=%b, required 1", ok);
        end
        do_write(15'h7FFF, 9'($urandom), ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL oob_max_handshake: accepted=%b, required 1", ok);
        end
    endtask

    task automatic test_collision;
        rgb9_t       c, d;
        logic [14:0] a;
        int          busy_n, n;
        bit          got;
        c = 9'($urandom);
        d = 9'($urandom);
        a = 15'($urandom_range(0, 319));
        busy_n = 0;
        n = 0;
        got = 1'b0;
        @(negedge clk25);
        bus.clr_color = c;
        bus.clr_start = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = a;
        bus.wr_data   = d;
        #1;
        tests++;
        if (bus.wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL collide_wr_ready: got %b, required 0", bus.wr_ready);
        end
        @(posedge clk25);
        #1;
        bus.clr_start = 1'b0;
        while (!got && n < 20500) begin
            @(negedge clk25);
            n++;
            if (bus.clr_busy === 1'b1) busy_n++;
            else if (bus.wr_ready === 1'b1) got = 1'b1;
        end
        @(posedge clk25);
        #1;
        bus.wr_valid = 1'b0;
        tests++;
        if (busy_n != 19200) begin
            fails++;
            $display("FAIL collide_busy_len: got %0d cycles, required 19200", busy_n);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL collide_held_write: accepted=%b, required 1", got);
        end
        for (int i = 0; i < 19200; i++) fb_model[i] = c;
        if (got) fb_model[a] = d;
        test_display(4, "coll");
    endtask

    task automatic test_clear_abort;
        rgb9_t ca, cb;
        int    busy_n, n;
        ca = 9'($urandom);
        cb = 9'($urandom);
        busy_n = 0;
        n = 0;
        @(negedge clk25);
        bus.clr_color = ca;
        bus.clr_start = 1'b1;
        @(posedge clk25);
        #1;
        bus.clr_start = 1'b0;
        repeat (100) @(posedge clk25);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.clr_busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_reset: busy=%b wr_ready=%b, required busy=0 wr_ready=1",
                     bus.clr_busy, bus.wr_ready);
        end
        for (int i = 0; i < 100; i++) fb_model[i] = ca;
        @(negedge clk25);
        rst = 1'b1;
        test_display(4, "abort");
        @(negedge clk25);
        bus.clr_color = cb;
        bus.clr_start = 1'b1;
        @(posedge clk25);
        #1;
        bus.clr_start = 1'b0;
        while (n < 20500) begin
            @(negedge clk25);
            n++;
            if (bus.clr_busy !== 1'b1) break;
            busy_n++;
        end
        tests++;
        if (busy_n != 19200) begin
            fails++;
            $display("FAIL refill_busy_len: got %0d cycles, required 19200", busy_n);
        end
        for (int i = 0; i < 19200; i++) fb_model[i] = cb;
        test_display(2, "refill");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_pixel_writes();
        test_out_of_range();
        test_collision();
        test_clear_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
